writeback_ctrl: RTL and testbench
=================================

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

Interface
REQ-001 Parameter LSU_DEPTH, default 4, gives the load-result FIFO depth; legal values are powers of two, 2 to 16.
REQ-002 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 Ports alu_valid_i (input, 1), alu_rd_addr_i (input, 5) and alu_data_i (input, 32): a single-cycle ALU result; always accepted, no ready signal.
REQ-005 Ports lsu_valid_i (input, 1), lsu_ready_o (output, 1), lsu_rd_addr_i (input, 5) and lsu_data_i (input, 32): the load-result channel, using a valid/ready handshake.
REQ-006 Ports issue_i (input, 1) and issue_rd_addr_i (input, 5): a load issued this cycle that targets issue_rd_addr_i.
REQ-007 Ports rs1_addr_i and rs2_addr_i (input, 5 each) and stall_o (output, 1): the hazard query and its result.
REQ-008 Ports rd_addr_o (output, 5), rd_data_o (output, 32) and rd_wren_o (output, 1): the register-file write port.

Function
REQ-009 The block SHALL issue at most one register-file write per cycle, with exactly one cycle of latency through a registered output stage.
REQ-010 Per cycle, the output stage SHALL load the ALU result if alu_valid_i is set; otherwise the FIFO head if the FIFO is non-empty; otherwise rd_wren_o SHALL be 0 in the next cycle.
REQ-011 An LSU beat SHALL be pushed into the FIFO when lsu_valid_i and lsu_ready_o are both 1.
REQ-012 lsu_ready_o SHALL be 1 whenever the FIFO is not full, combinational from the FIFO count; a pop in the same cycle does not free space for that cycle.
REQ-013 An ALU win SHALL hold the FIFO head in place; FIFO order SHALL be strict first-in, first-out.
REQ-014 Any write whose destination is address 0 SHALL be consumed normally, but rd_wren_o SHALL stay 0 for it.
REQ-015 A 32-bit pending scoreboard SHALL set bit issue_rd_addr_i at the next edge when issue_i is 1 and the address is non-zero.
REQ-016 A pending bit SHALL clear at the edge that completes an LSU-origin write to that address (rd_wren_o=1 during that cycle).
REQ-017 When set and clear hit the same address in the same cycle, set SHALL win.
REQ-018 An ALU write to a pending register SHALL complete without clearing the pending bit.
REQ-019 stall_o SHALL be combinational: pending[rs1_addr_i] | pending[rs2_addr_i] | (issue_i & pending[issue_rd_addr_i]); address 0 SHALL never stall.
REQ-020 A FIFO push and pop in the same cycle SHALL leave the count unchanged; the pointers SHALL wrap modulo LSU_DEPTH.

Reset
REQ-021 While rst_i is 1 at an edge: rd_wren_o, rd_addr_o and rd_data_o SHALL become 0, the FIFO SHALL become empty, and the scoreboard SHALL be cleared.
REQ-022 lsu_ready_o SHALL be 0 while rst_i is 1.
REQ-023 A reset asserted mid-operation SHALL discard all buffered load results and all pending bits, with no partial write issued.

Configuration
REQ-024 Macro WB_BYPASS_EN SHALL control forwarding.
- Defined: adds outputs rs1_fwd_o and rs2_fwd_o (1 bit each) and fwd_data_o (32 bits). A query that matches rd_addr_o while rd_wren_o=1 SHALL report fwd=1 with fwd_data_o=rd_data_o, and that register SHALL NOT contribute to stall_o.
- Undefined: these ports are absent and stall_o follows REQ-019 exactly.

Structure
REQ-025 A shared package SHALL hold REG_ADDR_W=5, XLEN=32, the wb_entry_t struct (addr, data, is_lsu) and the default LSU_DEPTH.
REQ-026 The FIFO SHALL be a sub-module, wb_fifo, parameterised by depth and entry type.

Verification
REQ-027 Scenario: ALU x5=0x0000_1234 at cycle 0 -> rd_wren_o=1, rd_addr_o=5, rd_data_o=0x0000_1234 at cycle 1.
REQ-028 Scenario: issue x7, then rs1_addr_i=7 -> stall_o=1 until the LSU write of x7=0xDEAD_BEEF completes; stall_o=0 the cycle after (with WB_BYPASS_EN: rs1_fwd_o=1 with data 0xDEAD_BEEF during the write cycle, stall_o=0).
REQ-029 Scenario: ALU valid every cycle for 6 cycles while LSU pushes 5 beats with LSU_DEPTH=4 -> lsu_ready_o drops after 4 pushes; the 5th beat is held; all 5 loads are written in order once the ALU goes idle.
REQ-030 Scenario: ALU to x0 and LSU to x0 -> rd_wren_o stays 0; the FIFO drains; the scoreboard is unchanged.
REQ-031 Scenario: issue x3 in the same cycle as the LSU write completes x3 -> pending[3] remains 1.
REQ-032 Scenario: rst_i pulsed with 3 FIFO entries and pending {x2, x9} -> the FIFO is empty, stall_o=0 and no write is issued after reset.

Source files
------------

// File: rtl/writeback_ctrl_pkg.sv
// Shared widths, write-back entry type and default load-FIFO depth for writeback_ctrl.
package writeback_ctrl_pkg;

  localparam int REG_ADDR_W        = 5;
  localparam int XLEN              = 32;
  localparam int NUM_REGS          = 1 << REG_ADDR_W;
  localparam int LSU_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
    logic                  is_lsu;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for write-back entries; DEPTH must be a power of two so the
// pointers wrap naturally and the count MSB alone signals full.
module wb_fifo
  import writeback_ctrl_pkg::*;
#(
  parameter int  DEPTH = LSU_DEPTH_DEFAULT,
  parameter type T     = wb_entry_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     data_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign full_o  = r_count[PW];
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; r_count alone decides which slots are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write-back arbiter (ALU over buffered loads) with a pending-load
// scoreboard for hazard stalls. Define WB_BYPASS_EN to add write-stage forwarding.
module writeback_ctrl
  import writeback_ctrl_pkg::*;
#(
  parameter int LSU_DEPTH = LSU_DEPTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_addr_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [REG_ADDR_W-1:0] lsu_rd_addr_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  input  logic                  issue_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  stall_o,
`ifdef WB_BYPASS_EN
  output logic                  rs1_fwd_o,
  output logic                  rs2_fwd_o,
  output logic [XLEN-1:0]       fwd_data_o,
`endif
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  rd_wren_o
);

  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_push;
  logic                w_pop;
  wb_entry_t           w_lsu_entry;
  wb_entry_t           w_fifo_head;
  wb_entry_t           r_wb;
  logic                r_wren;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic                w_rs1_fwd;
  logic                w_rs2_fwd;
  logic                w_rs1_hit;
  logic                w_rs2_hit;
  logic                w_issue_hit;

  assign lsu_ready_o = !w_fifo_full && !rst_i;
  assign w_push      = lsu_valid_i && lsu_ready_o;
  assign w_pop       = !alu_valid_i && !w_fifo_empty;
  assign w_lsu_entry = '{addr: lsu_rd_addr_i, data: lsu_data_i, is_lsu: 1'b1};

  wb_fifo #(
    .DEPTH (LSU_DEPTH),
    .T     (wb_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_lsu_entry),
    .data_o  (w_fifo_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Writes to x0 still occupy the output stage; only the enable is suppressed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wb   <= '0;
      r_wren <= 1'b0;
    end else if (alu_valid_i) begin
      r_wb   <= '{addr: alu_rd_addr_i, data: alu_data_i, is_lsu: 1'b0};
      r_wren <= (alu_rd_addr_i != '0);
    end else if (!w_fifo_empty) begin
      r_wb   <= w_fifo_head;
      r_wren <= (w_fifo_head.addr != '0);
    end else begin
      r_wren <= 1'b0;
    end
  end

  assign rd_addr_o = r_wb.addr;
  assign rd_data_o = r_wb.data;
  assign rd_wren_o = r_wren;

  // NOTE: both masks get a default before the conditional bit sets, so no latch is inferred.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (issue_i && (issue_rd_addr_i != '0)) w_set_mask[issue_rd_addr_i] = 1'b1;
    if (r_wren && r_wb.is_lsu)              w_clr_mask[r_wb.addr]       = 1'b1;
  end

  // Set is applied after clear so a re-issue racing the completing load keeps the bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

`ifdef WB_BYPASS_EN
  assign w_rs1_fwd  = r_wren && (r_wb.addr == rs1_addr_i);
  assign w_rs2_fwd  = r_wren && (r_wb.addr == rs2_addr_i);
  assign rs1_fwd_o  = w_rs1_fwd;
  assign rs2_fwd_o  = w_rs2_fwd;
  assign fwd_data_o = r_wb.data;
`else
  assign w_rs1_fwd  = 1'b0;
  assign w_rs2_fwd  = 1'b0;
`endif

  assign w_rs1_hit   = (rs1_addr_i != '0) && r_pending[rs1_addr_i] && !w_rs1_fwd;
  assign w_rs2_hit   = (rs2_addr_i != '0) && r_pending[rs2_addr_i] && !w_rs2_fwd;
  assign w_issue_hit = issue_i && (issue_rd_addr_i != '0) && r_pending[issue_rd_addr_i];
  assign stall_o     = w_rs1_hit || w_rs2_hit || w_issue_hit;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Scoreboard bench for writeback_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_writeback_ctrl;

  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          valid;
    bit          lsu;
    logic [4:0]  addr;
    logic [31:0] data;
  } cur_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_data;
  logic        issue;
  logic [4:0]  issue_rd_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        stall;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wren;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd;
  logic        rs2_fwd;
  logic [31:0] fwd_data;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  bit   last_accept;
  bit   m_known  = 1'b0;
  bit   m_pend [32];
  exp_t m_fifo [$];
  exp_t exp_q  [$];
  cur_t m_cur;

  writeback_ctrl #(.LSU_DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .alu_valid_i     (alu_valid),
    .alu_rd_addr_i   (alu_rd_addr),
    .alu_data_i      (alu_data),
    .lsu_valid_i     (lsu_valid),
    .lsu_ready_o     (lsu_ready),
    .lsu_rd_addr_i   (lsu_rd_addr),
    .lsu_data_i      (lsu_data),
    .issue_i         (issue),
    .issue_rd_addr_i (issue_rd_addr),
    .rs1_addr_i      (rs1_addr),
    .rs2_addr_i      (rs2_addr),
    .stall_o         (stall),
`ifdef WB_BYPASS_EN
    .rs1_fwd_o       (rs1_fwd),
    .rs2_fwd_o       (rs2_fwd),
    .fwd_data_o      (fwd_data),
`endif
    .rd_addr_o       (rd_addr),
    .rd_data_o       (rd_data),
    .rd_wren_o       (rd_wren)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit fwd_hit(input logic [4:0] a);
    return BYP && m_cur.valid && (m_cur.addr == a);
  endfunction

  function automatic bit blocked(input logic [4:0] a);
    return (a != 0) && m_pend[a] && !fwd_hit(a);
  endfunction

  // Monitor: every cycle either the scheduled write appears or the port is idle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("wb_wren", rd_wren, 1);
      check("wb_addr", rd_addr, e.addr);
      check("wb_data", rd_data, e.data);
    end else if (cyc > 0) begin
      check("wb_idle", rd_wren, 0);
    end
  end

  // One cycle: check combinational outputs against the model, then advance the model.
  task automatic step();
    bit   ready_exp;
    bit   stall_exp;
    cur_t nxt;
    exp_t e;
    #1;
    ready_exp = !rst && (m_fifo.size() < DEPTH);
    check("lsu_ready", lsu_ready, ready_exp);
    if (m_known) begin
      stall_exp = blocked(rs1_addr) || blocked(rs2_addr) ||
                  (issue && issue_rd_addr != 0 && m_pend[issue_rd_addr]);
      check("stall", stall, stall_exp);
`ifdef WB_BYPASS_EN
      check("rs1_fwd", rs1_fwd, fwd_hit(rs1_addr));
      check("rs2_fwd", rs2_fwd, fwd_hit(rs2_addr));
      if (m_cur.valid) check("fwd_data", fwd_data, m_cur.data);
`endif
    end
    last_accept = lsu_valid && ready_exp;
    if (rst) begin
      m_fifo.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_cur   = '{default: '0};
      m_known = 1'b1;
    end else begin
      nxt = '{default: '0};
      if (alu_valid) begin
        nxt = '{valid: (alu_rd_addr != 0), lsu: 1'b0, addr: alu_rd_addr, data: alu_data};
      end else if (m_fifo.size() > 0) begin
        e   = m_fifo.pop_front();
        nxt = '{valid: (e.addr != 0), lsu: 1'b1, addr: e.addr, data: e.data};
      end
      if (nxt.valid) exp_q.push_back('{addr: nxt.addr, data: nxt.data, cyc: cyc + 1});
      if (last_accept) m_fifo.push_back('{addr: lsu_rd_addr, data: lsu_data, cyc: 0});
      if (m_cur.valid && m_cur.lsu) m_pend[m_cur.addr] = 1'b0;
      if (issue && issue_rd_addr != 0) m_pend[issue_rd_addr] = 1'b1;
      m_cur = nxt;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd_addr = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd_addr = 0; lsu_data = 0;
    issue = 0; issue_rd_addr = 0; rs1_addr = 0; rs2_addr = 0;
  endtask

  initial begin
    int k;
    idle_inputs();
    rst = 1;
    step();
    step();
    check("rst_wren", rd_wren, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_data", rd_data, 0);
    rst = 0;

    // ALU write x5 appears one cycle later.
    alu_valid = 1; alu_rd_addr = 5; alu_data = 32'h0000_1234;
    step();
    alu_valid = 0;
    check("s027_wren", rd_wren, 1);
    check("s027_addr", rd_addr, 5);
    check("s027_data", rd_data, 32'h0000_1234);

    // Load to x7: stall until the LSU write completes.
    issue = 1; issue_rd_addr = 7;
    step();
    issue = 0; rs1_addr = 7;
    #1 check("s028_stall_pre", stall, 1);
    lsu_valid = 1; lsu_rd_addr = 7; lsu_data = 32'hDEAD_BEEF;
    step();
    lsu_valid = 0;
    step();
    #1 check("s028_write_x7", rd_addr, 7);
    check("s028_stall_wb", stall, !BYP);
    step();
    #1 check("s028_stall_post", stall, 0);
    rs1_addr = 0;

    // ALU busy for 6 cycles while 5 loads arrive.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_rd_addr = 5'(c + 1); alu_data = $urandom;
      lsu_valid = (k < 5); lsu_rd_addr = 5'(10 + k); lsu_data = 32'hA000_0000 + k;
      step();
      if (last_accept) k++;
    end
    check("s029_pushes", k, 4);
    #1 check("s029_ready_low", lsu_ready, 0);
    alu_valid = 0;
    for (int c = 0; c < 10 && k < 5; c++) begin
      lsu_rd_addr = 5'(10 + k); lsu_data = 32'hA000_0000 + k;
      step();
      if (last_accept) k++;
    end
    check("s029_fifth_taken", k, 5);
    lsu_valid = 0;
    repeat (6) step();

    // x0 traffic: consumed without a write enable.
    alu_valid = 1; alu_rd_addr = 0; alu_data = 32'h1111_1111;
    lsu_valid = 1; lsu_rd_addr = 0; lsu_data = 32'h2222_2222;
    step();
    idle_inputs();
    repeat (3) step();
    #1 check("s030_ready", lsu_ready, 1);

    // Re-issue of x3 racing its completing load keeps it pending.
    issue = 1; issue_rd_addr = 3;
    step();
    issue = 0;
    lsu_valid = 1; lsu_rd_addr = 3; lsu_data = 32'h3333_3333;
    step();
    lsu_valid = 0;
    step();
    issue = 1; issue_rd_addr = 3;
    step();
    issue = 0; rs1_addr = 3;
    #1 check("s031_still_pending", stall, 1);
    lsu_valid = 1; lsu_data = 32'h3333_4444;
    step();
    idle_inputs();
    repeat (3) step();

    // Reset mid-operation with buffered loads and pending x2/x9.
    issue = 1; issue_rd_addr = 2;
    step();
    issue_rd_addr = 9;
    step();
    issue = 0;
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_rd_addr = 1; alu_data = 32'hC0DE_0000 + c;
      lsu_valid = 1; lsu_rd_addr = 5'(20 + c); lsu_data = $urandom;
      step();
    end
    idle_inputs();
    rst = 1;
    step();
    rst = 0; rs1_addr = 2; rs2_addr = 9;
    #1 check("s032_stall", stall, 0);
    check("s032_ready", lsu_ready, 1);
    repeat (4) step();
    check("s032_no_write", rd_wren, 0);

    // Randomized traffic over a narrow address range to provoke hazards.
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      alu_valid     = ($urandom_range(0, 9) < 4);
      alu_rd_addr   = 5'($urandom_range(0, 7));
      alu_data      = $urandom;
      lsu_valid     = ($urandom_range(0, 1) == 1);
      lsu_rd_addr   = 5'($urandom_range(0, 7));
      lsu_data      = $urandom;
      issue         = ($urandom_range(0, 4) == 0);
      issue_rd_addr = 5'($urandom_range(0, 7));
      rs1_addr      = 5'($urandom_range(0, 7));
      rs2_addr      = 5'($urandom_range(0, 7));
      step();
    end
    rst = 0;
    idle_inputs();
    repeat (DEPTH + 4) step();
    check("drain_expected_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
